// File: rtl/store_buf_pkg.sv
// Shared defaults and types for the store buffer and its lookup logic.
// The optional in-place merge of stores is enabled by defining STORE_BUF_COALESCE_EN.
package store_buf_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  // Byte addresses are compared on word granularity; bits below this are ignored.
  localparam int unsigned WORD_LSB = 2;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buf_match.sv
// Parallel word-address compare over all buffer entries with a youngest-first
// priority select, so a load sees the most recent store to its word.
module store_buf_match
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned WA_W   = SB_ADDR_W - WORD_LSB,
  parameter int unsigned DATA_W = SB_DATA_W,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                         ld_valid_i,
  input  logic [WA_W-1:0]              ld_word_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][WA_W-1:0]   word_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]             tail_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [IDX_W-1:0] idx;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); a later match overrides.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    if (ld_valid_i) begin
      for (int k = DEPTH; k >= 1; k--) begin
        idx = tail_i - IDX_W'(k);
        if (valid_i[idx] && (word_i[idx] == ld_word_i)) begin
          hit_o  = 1'b1;
          data_o = data_i[idx];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write buffer between the MEM stage and a single-port data memory,
// with store-to-load forwarding. Define STORE_BUF_COALESCE_EN to merge stores in place.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  input  logic [ADDR_W-1:0]       st_addr_i,
  input  logic [DATA_W-1:0]       st_data_i,
  output logic                    st_ready_o,
  input  logic                    ld_valid_i,
  input  logic [ADDR_W-1:0]       ld_addr_i,
  output logic                    ld_hit_o,
  output logic [DATA_W-1:0]       ld_data_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic                    mem_ready_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned WA_W  = ADDR_W - WORD_LSB;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][WA_W-1:0]   word_addr;

  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx, tail_idx, young_idx;
  logic             full, empty, pop, push, coalesce_ok, coalesce;
  logic             unused_ld_lsb;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == PTR_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_idx  = rd_ptr_q[IDX_W-1:0];
  assign tail_idx  = wr_ptr_q[IDX_W-1:0];
  assign young_idx = tail_idx - IDX_W'(1);

  assign unused_ld_lsb = ^ld_addr_i[WORD_LSB-1:0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      word_addr[i] = addr_q[i][ADDR_W-1:WORD_LSB];
    end
  end

  store_buf_match #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W)
  ) u_match (
    .ld_valid_i (ld_valid_i),
    .ld_word_i  (ld_addr_i[ADDR_W-1:WORD_LSB]),
    .valid_i    (valid_q),
    .word_i     (word_addr),
    .data_i     (data_q),
    .tail_i     (tail_idx),
    .hit_o      (ld_hit_o),
    .data_o     (ld_data_o)
  );

  // A load that misses needs the memory port, so the drain yields that cycle.
  assign mem_we_o    = !empty && !(ld_valid_i && !ld_hit_o);
  assign mem_addr_o  = empty ? '0 : addr_q[head_idx];
  assign mem_wdata_o = empty ? '0 : data_q[head_idx];
  assign pop         = mem_we_o && mem_ready_i;

`ifdef STORE_BUF_COALESCE_EN
  // Merging into the head while it drains would lose the new data, so that case allocates.
  assign coalesce_ok = !empty
                    && (word_addr[young_idx] == st_addr_i[ADDR_W-1:WORD_LSB])
                    && !(pop && (young_idx == head_idx));
`else
  assign coalesce_ok = 1'b0;
`endif

  assign st_ready_o = !full || coalesce_ok;
  assign coalesce   = st_valid_i && coalesce_ok;
  assign push       = st_valid_i && st_ready_o && !coalesce;
  assign count_o    = count;
  assign empty_o    = empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    valid_d  = valid_q;
    if (pop)  valid_d[head_idx] = 1'b0;
    if (push) valid_d[tail_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; valid bits and the empty gate keep stale contents invisible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_idx] <= st_addr_i;
      data_q[tail_idx] <= st_data_i;
    end
    if (coalesce) begin
      data_q[young_idx] <= st_data_i;
    end
  end

  illegal_st_and_ld: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(st_valid_i && ld_valid_i));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// compared against a queue-based reference model of the buffer's rules.
module tb_store_buffer;
  import store_buf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i, ld_valid_i, mem_ready_i;
  logic [31:0] st_addr_i, st_data_i, ld_addr_i;
  logic        st_ready_o, ld_hit_o, mem_we_o, empty_o;
  logic [31:0] ld_data_o, mem_addr_o, mem_wdata_o;
  logic [2:0]  count_o;

  sb_entry_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .st_valid_i  (st_valid_i),
    .st_addr_i   (st_addr_i),
    .st_data_i   (st_data_i),
    .st_ready_o  (st_ready_o),
    .ld_valid_i  (ld_valid_i),
    .ld_addr_i   (ld_addr_i),
    .ld_hit_o    (ld_hit_o),
    .ld_data_o   (ld_data_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .count_o     (count_o),
    .empty_o     (empty_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic word_eq(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  // Youngest matching store wins: search from the back of the queue.
  function automatic logic model_lookup(output logic [31:0] d);
    d = '0;
    if (!ld_valid_i) return 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (word_eq(q[i].addr, ld_addr_i)) begin
        d = q[i].data;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic model_coal_ok(input logic popping);
`ifdef STORE_BUF_COALESCE_EN
    return (q.size() > 0) && word_eq(q[q.size()-1].addr, st_addr_i)
        && !(popping && q.size() == 1);
`else
    return popping && 1'b0;
`endif
  endfunction

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic mr);
    st_valid_i  = sv;
    st_addr_i   = sa;
    st_data_i   = sd;
    ld_valid_i  = lv;
    ld_addr_i   = la;
    mem_ready_i = mr;
    #1;
  endtask

  // Compare all outputs against the model, then advance model and DUT one clock.
  task automatic tick(input string tag);
    logic [31:0] d;
    logic        hit, we, pop, cok, rdy;
    sb_entry_t   e;
    hit = model_lookup(d);
    we  = (q.size() > 0) && !(ld_valid_i && !hit);
    pop = we && mem_ready_i;
    cok = model_coal_ok(pop);
    rdy = (q.size() < DEPTH) || cok;
    check({tag, ".st_ready"}, st_ready_o, rdy);
    check({tag, ".ld_hit"},   ld_hit_o,   hit);
    check({tag, ".ld_data"},  ld_data_o,  d);
    check({tag, ".mem_we"},   mem_we_o,   we);
    check({tag, ".mem_addr"}, mem_addr_o, (q.size() > 0) ? q[0].addr : 32'h0);
    check({tag, ".mem_wdata"}, mem_wdata_o, (q.size() > 0) ? q[0].data : 32'h0);
    check({tag, ".count"},    count_o,    q.size());
    check({tag, ".empty"},    empty_o,    q.size() == 0);
    if (st_valid_i && cok) begin
      e = q[q.size()-1];
      e.data = st_data_i;
      q[q.size()-1] = e;
    end
    if (pop) void'(q.pop_front());
    if (st_valid_i && rdy && !cok) q.push_back('{addr: st_addr_i, data: st_data_i});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick(tag);
    end
    drive(0, 0, 0, 0, 0, 1);
    check({tag, ".empty_after_drain"}, empty_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("reset.empty",    empty_o,    1'b1);
    check("reset.count",    count_o,    3'd0);
    check("reset.st_ready", st_ready_o, 1'b1);
    check("reset.mem_we",   mem_we_o,   1'b0);
    check("reset.ld_hit",   ld_hit_o,   1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Fill with the memory stalled; a fifth store must be refused.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'hD000 + 32'(i), 0, 0, 0);
      tick("fill");
    end
    drive(1, 32'h110, 32'hDEAD, 0, 0, 0);
    check("full.count",    count_o,    3'd4);
    check("full.st_ready", st_ready_o, 1'b0);
    tick("fifth");
    drive(0, 0, 0, 0, 0, 0);
    check("refused.count", count_o,    3'd4);
    check("refused.head",  mem_addr_o, 32'h100);
    tick("refused");
    drain("drain1");

    // Youngest store to a word is forwarded.
    drive(1, 32'h200, 32'hAAAA, 0, 0, 0); tick("fwd_st0");
    drive(1, 32'h200, 32'hBBBB, 0, 0, 0); tick("fwd_st1");
    drive(0, 0, 0, 1, 32'h202, 0);
    check("fwd.hit",  ld_hit_o,  1'b1);
    check("fwd.data", ld_data_o, 32'hBBBB);
`ifdef STORE_BUF_COALESCE_EN
    check("fwd.count", count_o, 3'd1);
`else
    check("fwd.count", count_o, 3'd2);
`endif
    tick("fwd_ld");

    // A load miss owns the port; the drain resumes on the next idle cycle.
    drive(0, 0, 0, 1, 32'h300, 1);
    check("miss.mem_we", mem_we_o, 1'b0);
    check("miss.hit",    ld_hit_o, 1'b0);
    tick("miss");
    drive(0, 0, 0, 0, 0, 1);
    check("resume.mem_we", mem_we_o, 1'b1);
    tick("resume");
    drain("drain2");

    // Full with a pop in the same cycle: store still refused.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 32'hC000 + 32'(i), 0, 0, 0);
      tick("fill2");
    end
    drive(1, 32'h500, 32'h5555, 0, 0, 1);
    check("fullpop.st_ready", st_ready_o, 1'b0);
    check("fullpop.mem_we",   mem_we_o,   1'b1);
    tick("fullpop");
    drive(1, 32'h500, 32'h5555, 0, 0, 0);
    check("afterpop.count",    count_o,    3'd3);
    check("afterpop.st_ready", st_ready_o, 1'b1);
    tick("afterpop");
    drive(0, 0, 0, 0, 0, 0);
    check("refill.count", count_o, 3'd4);
    tick("refill");
    drain("drain3");

    // Streaming push/pop across several pointer wraps; the model checks drain order.
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h600 + 32'(4 * i), 32'h6000 + 32'(i), 0, 0, 1);
      tick("wrap");
    end
    drain("wrap_drain");

    // Random traffic over a small address pool so hits and misses both occur.
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'h700 + 32'(4 * $urandom_range(0, 5));
      if (op == 1)
        drive(1, a, $urandom, 0, 0, 1'($urandom_range(0, 1)));
      else if (op == 2)
        drive(0, 0, 0, 1, a + 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        drive(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      tick("rand");
    end
    drain("rand_drain");

    // Reset mid-drain discards everything immediately.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h800 + 32'(4 * i), 32'h8000 + 32'(i), 0, 0, 0);
      tick("pre_rst");
    end
    drive(0, 0, 0, 0, 0, 1);
    check("pre_rst.mem_we", mem_we_o, 1'b1);
    #1;
    rst_i = 1'b0;
    #1;
    q.delete();
    check("rst.mem_we",   mem_we_o,   1'b0);
    check("rst.count",    count_o,    3'd0);
    check("rst.empty",    empty_o,    1'b1);
    check("rst.st_ready", st_ready_o, 1'b1);
    check("rst.mem_addr", mem_addr_o, 32'h0);
    @(posedge clk_i);
    #1;
    check("rst_hold.mem_we", mem_we_o, 1'b0);
    check("rst_hold.count",  count_o,  3'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    tick("post_rst0");
    tick("post_rst1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small FIFO write buffer between the MEM stage and the single-port data memory, i.e. the reader side of store data.
- Accepts stores from the pipeline in one cycle and drains them to memory in order when the port is free.
- Serves loads by forwarding the youngest buffered store to the same word, so loads never read stale memory.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
st_valid_i  input  1  MEM-stage store request
st_addr_i  input  ADDR_W  store byte address (word aligned)
st_data_i  input  DATA_W  store data
st_ready_o  output  1  buffer can accept a store this cycle
ld_valid_i  input  1  MEM-stage load request
ld_addr_i  input  ADDR_W  load byte address
ld_hit_o  output  1  load word address matches a resident entry
ld_data_o  output  DATA_W  forwarded data from the youngest matching entry; 0 when no hit
mem_we_o  output  1  drain write strobe to data memory
mem_addr_o  output  ADDR_W  drain address (head entry)
mem_wdata_o  output  DATA_W  drain data (head entry)
mem_ready_i  input  1  memory accepts the write this cycle
count_o  output  $clog2(DEPTH)+1  occupied entries
empty_o  output  1  count_o == 0

Behaviour:
- Reset (rst_i low, async): all entries invalid, head/tail pointers 0, count 0. st_ready_o=1, mem_we_o=0, ld_hit_o=0, ld_data_o=0, count_o=0, empty_o=1. Reset mid-drain discards all entries; no write completes after reset asserts.
- Push: st_valid_i && st_ready_o at the clock edge writes {addr,data} at tail. Tail advances mod DEPTH. 1-cycle latency: entry visible to lookup and drain the next cycle.
- st_ready_o = (count < DEPTH). Combinational from state only; does not depend on same-cycle pop.
- Drain: mem_we_o = !empty && !(ld_valid_i && !ld_hit_o). A load miss owns the memory port, so drain yields that cycle. mem_addr_o/mem_wdata_o always show head (0 when empty). Pop when mem_we_o && mem_ready_i; head advances mod DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance. When full with a pop in the same cycle, the store is still refused (st_ready_o=0).
- Lookup (combinational): compare ld_addr_i[ADDR_W-1:2] against every valid entry. ld_hit_o=1 if any match. ld_data_o comes from the youngest match, i.e. nearest to tail. The head entry being popped this cycle still counts as resident. ld_hit_o=0 when ld_valid_i=0.
- A store pushed in the current cycle is not visible to a same-cycle load.
- st_valid_i and ld_valid_i both high is illegal. The store is accepted, lookup still runs, and a simulation assertion fires.
- Pointer wrap: DEPTH power of two; pointers carry one extra bit to distinguish full from empty.

Optional Feature:
- Macro STORE_BUF_COALESCE_EN.
- When defined: a store whose word address equals the youngest resident entry overwrites that entry's data in place. Count is unchanged and the store is accepted even when full. Exception: if that entry is the head being popped this cycle, the store allocates normally.
- When undefined: every accepted store allocates a new entry.

Decomposition:
- Package store_buf_pkg: DEPTH/ADDR_W/DATA_W defaults, entry struct typedef {addr, data}, word-address slice constant.
- One sub-module store_buf_match: DEPTH-wide compare plus youngest-first priority select, returning hit and data.

Test Plan:
- Reset -> empty_o=1, count_o=0, st_ready_o=1, mem_we_o=0. Release reset, hold mem_ready_i=0, push 4 stores 0x100..0x10C -> count_o=4, st_ready_o=0, and a 5th store is refused.
- Stores 0x200<=0xAAAA then 0x200<=0xBBBB (macro off), load 0x200 -> ld_hit_o=1, ld_data_o=0xBBBB. Same sequence with macro on -> count_o=1.
- Load 0x300 (miss) while buffer non-empty, mem_ready_i=1 -> mem_we_o=0 that cycle. Next idle cycle -> mem_we_o=1, head pops.
- Full buffer, mem_ready_i=1 and st_valid_i in the same cycle -> pop occurs, store refused, count_o=3. Next cycle store accepted, count_o=4.
- Drain across wrap: push/pop 10 stores in sequence -> mem_addr_o order matches push order, empty_o=1 at end.
- Assert rst_i low with 3 entries and mem_we_o=1 -> outputs return to reset values immediately, no further writes.
